// File: rtl/bubble_out_sequencer_pkg.sv
// Mode-state encodings and window-boundary helpers for the bubble output sequencer.
package bubble_pkg;

  typedef enum logic [2:0] {
    BOOT       = 3'b000,
    INIT_STBY  = 3'b010,
    NORM_ACC   = 3'b100,
    PAGE_LATCH = 3'b101,
    NORM_STBY  = 3'b110
  } mode_state_e;

  function automatic int boot_total(input int pre, input int sl, input int dl, input int tl);
    return pre + sl + dl + tl + 3;
  endfunction

  function automatic int page_total(input int pre, input int dl);
    return pre + dl + 91;
  endfunction

  function automatic int boot_start_lo(input int pre);
    return pre + 1;
  endfunction

  function automatic int boot_data_lo(input int pre, input int sl);
    return pre + sl + 1;
  endfunction

  function automatic int boot_tail_lo(input int pre, input int sl, input int dl);
    return pre + sl + dl + 1;
  endfunction

  function automatic int page_data_lo(input int pre);
    return pre + 1;
  endfunction

  // Bit numbers are 1-based; a window covers [lo, lo+len).
  function automatic logic in_win(input int n, input int lo, input int len);
    return (n >= lo) && (n < lo + len);
  endfunction

endpackage

// File: rtl/bubble_out_sequencer_if.sv
// Timing-generator, loader and bubble-output signals of the sequencer.
interface bubble_out_sequencer_if #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 11
);
  logic                i_bubble_module_enable;
  logic                i_position_change;
  logic                i_data_out_strobe;
  logic                i_position_latch;
  logic                i_page_select;
  logic                i_coil_enable;
  logic                i_buf_wr_en;
  logic [ADDR_W-1:0]   i_buf_wr_addr;
  logic [CHANNELS-1:0] i_buf_wr_data;
  logic                i_buf_ready;
  logic                o_load_bootloader;
  logic                o_load_page;
  logic                o_convert;
  logic [11:0]         o_bubble_position_output;
  logic                o_underrun;
  logic [CHANNELS-1:0] o_bubble_out;

  modport master (
    output i_bubble_module_enable, i_position_change, i_data_out_strobe, i_position_latch,
           i_page_select, i_coil_enable, i_buf_wr_en, i_buf_wr_addr, i_buf_wr_data, i_buf_ready,
    input  o_load_bootloader, o_load_page, o_convert, o_bubble_position_output, o_underrun,
           o_bubble_out
  );

  modport slave (
    input  i_bubble_module_enable, i_position_change, i_data_out_strobe, i_position_latch,
           i_page_select, i_coil_enable, i_buf_wr_en, i_buf_wr_addr, i_buf_wr_data, i_buf_ready,
    output o_load_bootloader, o_load_page, o_convert, o_bubble_position_output, o_underrun,
           o_bubble_out
  );
endinterface

// File: rtl/bubble_out_sequencer_buffer_ram.sv
// Simple dual-port channel buffer; registered read, old data on same-address collision.
module bubble_buffer_ram #(
  parameter int ADDR_W   = 11,
  parameter int CHANNELS = 2
) (
  input  logic                i_clk,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [CHANNELS-1:0] i_wr_data,
  input  logic                i_rd_en,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [CHANNELS-1:0] o_rd_data
);
  logic [CHANNELS-1:0] r_mem [2**ADDR_W];
  logic [CHANNELS-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/bubble_out_sequencer.sv
// Bubble memory read-out emulator: mode decode, bit sequencing, position counter.
module bubble_out_sequencer
  import bubble_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int ADDR_W        = 11,
  parameter int POSITIONS     = 2053,
  parameter int POS_INIT      = 1464,
  parameter int BOOT_PRE_LEN  = 2640,
  parameter int START_LEN     = 2,
  parameter logic [START_LEN*CHANNELS-1:0] START_PATTERN = {2'b10, 2'b00},
  parameter int BOOT_DATA_LEN = 1920,
  parameter int BOOT_TAIL_LOW = 6,
  parameter int PAGE_PRE_LEN  = 100,
  parameter int PAGE_DATA_LEN = 512
) (
  input  logic i_master_clock,
  input  logic i_reset,
  bubble_out_sequencer_if.slave bus
);
  localparam int BOOT_TOT = boot_total(BOOT_PRE_LEN, START_LEN, BOOT_DATA_LEN, BOOT_TAIL_LOW);
  localparam int PAGE_TOT = page_total(PAGE_PRE_LEN, PAGE_DATA_LEN);
  localparam int CNT_W    = $clog2(((BOOT_TOT > PAGE_TOT) ? BOOT_TOT : PAGE_TOT) + 1);

  // Sync vector: [4] page_select, [3] coil_enable, [2] position_latch, [1] strobe, [0] position_change
  logic [4:0]          r_q;
  logic [1:0]          r_qq;
  mode_state_e         r_state, w_state_nxt;
  logic                r_lb, r_lp, w_lb_nxt, w_lp_nxt;
  logic                r_convert, r_underrun, r_first;
  logic [11:0]         r_pos;
  logic [CNT_W-1:0]    r_cnt, w_tot;
  logic [ADDR_W-1:0]   r_addr;
  logic [CHANNELS-1:0] r_out, w_out_nxt, w_rd_data;
  logic [2:0]          w_mode;
  logic                w_pc_rise, w_st_rise, w_st_fall, w_entry;
  logic                w_boot, w_active, w_data_win, w_pf;
  logic [31:0]         w_n1, w_ni;
  int                  w_sidx;

  assign w_mode    = r_q[4:2];
  assign w_pc_rise = r_q[0] & ~r_qq[0];
  assign w_st_rise = r_q[1] & ~r_qq[1];
  assign w_st_fall = ~r_q[1] & r_qq[1];

  always_comb begin
    w_state_nxt = r_state;
    w_lb_nxt    = r_lb;
    w_lp_nxt    = r_lp;
    case (w_mode)
      3'b000:  if (r_state != NORM_ACC && r_state != PAGE_LATCH) w_state_nxt = BOOT;
      3'b010:  if (r_state != PAGE_LATCH) w_state_nxt = INIT_STBY;
      3'b100:  w_state_nxt = NORM_ACC;
      3'b101:  if (r_state == NORM_ACC) w_state_nxt = PAGE_LATCH;
      3'b110:  if (r_state != PAGE_LATCH) w_state_nxt = NORM_STBY;
      default: w_state_nxt = r_state;
    endcase
    case (w_state_nxt)
      BOOT:       begin w_lb_nxt = 1'b0; w_lp_nxt = 1'b1; end
      PAGE_LATCH: begin w_lb_nxt = 1'b1; w_lp_nxt = 1'b0; end
      INIT_STBY,
      NORM_STBY:  begin w_lb_nxt = 1'b1; w_lp_nxt = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge i_master_clock) begin
    if (i_reset) begin
      r_state <= INIT_STBY;
      r_lb    <= 1'b1;
      r_lp    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_lb    <= w_lb_nxt;
      r_lp    <= w_lp_nxt;
    end
  end

  assign w_entry    = (r_lb & ~w_lb_nxt) | (r_lp & ~w_lp_nxt);
  assign w_boot     = ~r_lb;
  assign w_active   = ~r_lb | ~r_lp;
  assign w_tot      = w_boot ? CNT_W'(BOOT_TOT) : CNT_W'(PAGE_TOT);
  assign w_n1       = 32'(r_cnt) + 32'd1;
  assign w_ni       = (r_cnt == w_tot) ? 32'(r_cnt) : w_n1;
  assign w_data_win = w_boot ? in_win(w_n1, boot_data_lo(BOOT_PRE_LEN, START_LEN), BOOT_DATA_LEN)
                             : in_win(w_n1, page_data_lo(PAGE_PRE_LEN), PAGE_DATA_LEN);
  assign w_pf       = w_active & w_st_rise & w_data_win & ~w_entry;

  bubble_buffer_ram #(.ADDR_W(ADDR_W), .CHANNELS(CHANNELS)) u_ram (
    .i_clk     (i_master_clock),
    .i_wr_en   (bus.i_buf_wr_en),
    .i_wr_addr (bus.i_buf_wr_addr),
    .i_wr_data (bus.i_buf_wr_data),
    .i_rd_en   (w_pf),
    .i_rd_addr (r_addr),
    .o_rd_data (w_rd_data)
  );

  // Between strobe falls the output holds; leaving the mode forces idle-high.
  always_comb begin
    w_out_nxt = r_out;
    w_sidx    = int'(w_ni) - boot_start_lo(BOOT_PRE_LEN);
    if (!w_active) begin
      w_out_nxt = '1;
    end else if (w_st_fall) begin
      w_out_nxt = '1;
      if (w_boot) begin
        if (in_win(w_ni, boot_start_lo(BOOT_PRE_LEN), START_LEN))
          w_out_nxt = ~START_PATTERN[(START_LEN-1-w_sidx)*CHANNELS +: CHANNELS];
        else if (in_win(w_ni, boot_data_lo(BOOT_PRE_LEN, START_LEN), BOOT_DATA_LEN))
          w_out_nxt = r_underrun ? '1 : ~w_rd_data;
        else if (in_win(w_ni, boot_tail_lo(BOOT_PRE_LEN, START_LEN, BOOT_DATA_LEN), BOOT_TAIL_LOW))
          w_out_nxt = '0;
      end else if (in_win(w_ni, page_data_lo(PAGE_PRE_LEN), PAGE_DATA_LEN)) begin
        w_out_nxt = r_underrun ? '1 : ~w_rd_data;
      end
    end
  end

  always_ff @(posedge i_master_clock) begin
    if (i_reset) begin
      r_q        <= 5'b01000;
      r_qq       <= '0;
      r_convert  <= 1'b0;
      r_pos      <= 12'(POS_INIT);
      r_cnt      <= '0;
      r_addr     <= '0;
      r_underrun <= 1'b0;
      r_first    <= 1'b0;
      r_out      <= '1;
    end else begin
      r_q       <= {bus.i_page_select, bus.i_coil_enable, bus.i_position_latch,
                    bus.i_data_out_strobe, bus.i_position_change};
      r_qq      <= r_q[1:0];
      r_convert <= r_q[2];
      r_out     <= w_out_nxt;
      if (w_pc_rise) r_pos <= (r_pos == 12'(POSITIONS-1)) ? '0 : r_pos + 12'd1;
      if (w_entry) begin
        r_cnt      <= '0;
        r_addr     <= '0;
        r_underrun <= 1'b0;
        r_first    <= 1'b1;
      end else if (w_active) begin
        if (w_st_fall && r_cnt != w_tot) r_cnt <= r_cnt + 1'b1;
        if (w_pf) begin
          r_addr <= r_addr + 1'b1;
          if (r_first) begin
            r_underrun <= ~bus.i_buf_ready;
            r_first    <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.o_load_bootloader        = r_lb;
  assign bus.o_load_page              = r_lp;
  assign bus.o_convert                = r_convert;
  assign bus.o_bubble_position_output = r_pos;
  assign bus.o_underrun               = r_underrun;
  assign bus.o_bubble_out             = bus.i_bubble_module_enable ? '0 : r_out;
endmodule

// File: tb/tb_bubble_out_sequencer.sv
// Directed bench: table-driven boot/page bit checks plus mode, underrun and reset sequences.
module tb_bubble_out_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  bubble_out_sequencer_if #(.CHANNELS(2), .ADDR_W(11)) bus();
  bubble_out_sequencer dut (.i_master_clock(clk), .i_reset(rst), .bus(bus));

  typedef struct { int n; logic [1:0] exp; } vec_t;
  vec_t boot_v[15];
  vec_t page_v[8];
  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_mode(input logic ps, input logic ce, input logic pl);
    @(negedge clk);
    bus.i_page_select = ps; bus.i_coil_enable = ce; bus.i_position_latch = pl;
    repeat (4) @(negedge clk);
  endtask

  task automatic strobe();
    bus.i_data_out_strobe = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_data_out_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pos_pulse();
    bus.i_position_change = 1'b1;
    repeat (2) @(negedge clk);
    bus.i_position_change = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic fill(input bit page, input int count);
    logic [10:0] a;
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      a = 11'(i);
      bus.i_buf_wr_en   = 1'b1;
      bus.i_buf_wr_addr = a;
      bus.i_buf_wr_data = page ? {a[0], ~a[0]} : a[1:0];
    end
    @(negedge clk);
    bus.i_buf_wr_en = 1'b0;
  endtask

  initial begin
    int bi;
    // boot buffer mem[i] = i[1:0]; output is the inverse
    boot_v = '{'{1, 2'b11}, '{2640, 2'b11}, '{2641, 2'b01}, '{2642, 2'b11},
               '{2643, 2'b11}, '{2644, 2'b10}, '{2645, 2'b01}, '{2646, 2'b00},
               '{4561, 2'b01}, '{4562, 2'b00}, '{4563, 2'b00}, '{4568, 2'b00},
               '{4569, 2'b11}, '{4571, 2'b11}, '{4572, 2'b11}};
    // page buffer mem[i] = {i[0], ~i[0]}
    page_v = '{'{1, 2'b11}, '{100, 2'b11}, '{101, 2'b10}, '{102, 2'b01},
               '{612, 2'b01}, '{613, 2'b11}, '{703, 2'b11}, '{704, 2'b11}};

    rst = 1'b1;
    bus.i_bubble_module_enable = 1'b0;
    bus.i_position_change = 1'b0; bus.i_data_out_strobe = 1'b0;
    bus.i_page_select = 1'b0; bus.i_coil_enable = 1'b1; bus.i_position_latch = 1'b0;
    bus.i_buf_wr_en = 1'b0; bus.i_buf_wr_addr = '0; bus.i_buf_wr_data = '0;
    bus.i_buf_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_lb", bus.o_load_bootloader, 1);
    chk("rst_lp", bus.o_load_page, 1);
    chk("rst_convert", bus.o_convert, 0);
    chk("rst_pos", bus.o_bubble_position_output, 1464);
    chk("rst_underrun", bus.o_underrun, 0);
    chk("rst_out", bus.o_bubble_out, 2'b11);
    bus.i_bubble_module_enable = 1'b1; #1;
    chk("rst_out_disabled", bus.o_bubble_out, 2'b00);
    bus.i_bubble_module_enable = 1'b0;

    repeat (12) pos_pulse();
    chk("pos_12", bus.o_bubble_position_output, 1476);
    repeat (576) pos_pulse();
    chk("pos_last", bus.o_bubble_position_output, 2052);
    pos_pulse();
    chk("pos_wrap", bus.o_bubble_position_output, 0);

    fill(1'b0, 1920);
    set_mode(0, 0, 0);
    chk("boot_lb", bus.o_load_bootloader, 0);
    chk("boot_lp", bus.o_load_page, 1);
    bi = 0;
    for (int n = 1; n <= 4572; n++) begin
      strobe();
      if (bi < 15 && boot_v[bi].n == n) begin
        chk($sformatf("boot_bit%0d", n), bus.o_bubble_out, boot_v[bi].exp);
        bi++;
      end
    end
    chk("boot_underrun", bus.o_underrun, 0);

    // underrun: loader not ready at the first data prefetch
    set_mode(1, 1, 0);
    chk("stby_lb", bus.o_load_bootloader, 1);
    chk("stby_out", bus.o_bubble_out, 2'b11);
    bus.i_buf_ready = 1'b0;
    set_mode(0, 0, 0);
    chk("ur_entry_clear", bus.o_underrun, 0);
    for (int n = 1; n <= 2644; n++) begin
      strobe();
      if (n == 2641) chk("ur_start", bus.o_bubble_out, 2'b01);
      if (n == 2643) chk("ur_bit2643", bus.o_bubble_out, 2'b11);
      if (n == 2644) chk("ur_bit2644", bus.o_bubble_out, 2'b11);
    end
    chk("ur_set", bus.o_underrun, 1);
    set_mode(1, 1, 0);
    chk("ur_sticky", bus.o_underrun, 1);
    bus.i_buf_ready = 1'b1;
    set_mode(0, 0, 0);
    chk("ur_reentry_clear", bus.o_underrun, 0);

    fill(1'b1, 512);
    set_mode(1, 1, 0);
    set_mode(1, 0, 0);
    set_mode(1, 0, 1);
    chk("page_lp", bus.o_load_page, 0);
    chk("page_lb", bus.o_load_bootloader, 1);
    chk("page_convert", bus.o_convert, 1);
    bi = 0;
    for (int n = 1; n <= 704; n++) begin
      strobe();
      if (bi < 8 && page_v[bi].n == n) begin
        chk($sformatf("page_bit%0d", n), bus.o_bubble_out, page_v[bi].exp);
        bi++;
      end
    end
    chk("page_underrun", bus.o_underrun, 0);

    // glitches while latched must not leave PAGE_LATCH
    set_mode(0, 1, 0);
    chk("glitch_010_lp", bus.o_load_page, 0);
    set_mode(1, 1, 0);
    chk("glitch_110_lp", bus.o_load_page, 0);
    set_mode(0, 0, 0);
    chk("glitch_000_lb", bus.o_load_bootloader, 1);

    set_mode(1, 0, 0);
    chk("normacc_hold_lp", bus.o_load_page, 0);
    chk("normacc_convert", bus.o_convert, 0);
    set_mode(1, 1, 0);
    chk("normstby_lp", bus.o_load_page, 1);
    set_mode(1, 0, 0);
    set_mode(1, 0, 1);
    repeat (102) strobe();
    chk("mid_bit102", bus.o_bubble_out, 2'b01);
    bus.i_bubble_module_enable = 1'b1; #1;
    chk("mid_disable", bus.o_bubble_out, 2'b00);
    bus.i_bubble_module_enable = 1'b0; #1;
    chk("mid_enable", bus.o_bubble_out, 2'b01);

    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_lp", bus.o_load_page, 1);
    chk("mid_rst_out", bus.o_bubble_out, 2'b11);
    chk("mid_rst_pos", bus.o_bubble_position_output, 1464);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_lp", bus.o_load_page, 1);
    strobe();
    chk("post_rst_out", bus.o_bubble_out, 2'b11);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
